// File: rtl/regbank_pkg.sv
// Shared constants and default-width types for the physical register file.
// No logic of its own, so there is no latency.
// No flow control: this package only declares types.
package regbank_pkg;

  localparam int PREG_AWIDTH = 7;
  localparam int PREG_DWIDTH = 32;

  // Physical register 0 is hardwired: it always reads 0 and is always ready.
  localparam int PREG_ZERO = 0;

  typedef logic [PREG_AWIDTH-1:0] preg_addr_t;
  typedef logic [PREG_DWIDTH-1:0] preg_data_t;

endpackage

// File: rtl/regbank_bypass_mux.sv
// Operand select for one read port: picks between the forwarded write bus and the array word.
// Latency: combinational.
// No backpressure: write-back buses are always accepted.
module regbank_bypass_mux
  import regbank_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 7,
  parameter int WRITE_PORT = 2,
  parameter int BYPASS     = 1
) (
  input  logic [AWIDTH-1:0]                  read_addr,
  input  logic [WRITE_PORT-1:0]              write_valid,
  input  logic [WRITE_PORT-1:0][AWIDTH-1:0]  write_address,
  input  logic [WRITE_PORT-1:0][DWIDTH-1:0]  write_data,
  input  logic [DWIDTH-1:0]                  array_data,
  input  logic                               array_valid,
  output logic [DWIDTH-1:0]                  sel_data,
  output logic                               sel_ready
);

  localparam logic [AWIDTH-1:0] ZERO_ADDR = AWIDTH'(PREG_ZERO);

  logic              hit;
  logic [DWIDTH-1:0] hit_data;

  // Find a matching write this cycle; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WRITE_PORT; w++) begin
      if (write_valid[w] && (write_address[w] == read_addr)) begin
        hit      = 1'b1;
        hit_data = write_data[w];
      end
    end
  end

  // Address 0 overrides everything; a bypass hit beats the stored word when forwarding is enabled.
  always_comb begin
    sel_data  = array_data;
    sel_ready = array_valid;
    if (read_addr == ZERO_ADDR) begin
      sel_data  = '0;
      sel_ready = 1'b1;
    end else if ((BYPASS != 0) && hit) begin
      sel_data  = hit_data;
      sel_ready = 1'b1;
    end
  end

endmodule

// File: rtl/regbank_mp.sv
// Multi-ported physical register file with ready scoreboard and same-address write conflict flag.
// Latency: reads 0 or 1 cycle (READ_LATENCY); writes/invalidates visible in register_valid after one edge.
// No backpressure: every write, invalidate and read is accepted each cycle.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 7,
  parameter int READ_PORT    = 2,
  parameter int WRITE_PORT   = 2,
  parameter int INV_PORT     = 1,
  parameter int BYPASS       = 1,
  parameter int READ_LATENCY = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [WRITE_PORT-1:0]              write_valid,
  input  logic [WRITE_PORT-1:0][AWIDTH-1:0]  write_address,
  input  logic [WRITE_PORT-1:0][DWIDTH-1:0]  write_data,
  input  logic [READ_PORT-1:0][AWIDTH-1:0]   read_addr,
  output logic [READ_PORT-1:0][DWIDTH-1:0]   read_data,
  output logic [READ_PORT-1:0]               read_ready,
  input  logic [INV_PORT-1:0][AWIDTH-1:0]    invalidate_register,
  output logic [2**AWIDTH-1:0]               register_valid,
  output logic                               write_conflict
);

  localparam int DEPTH = 2**AWIDTH;

  typedef logic [AWIDTH-1:0] addr_t;
  typedef logic [DWIDTH-1:0] data_t;

  localparam addr_t ZERO_ADDR = AWIDTH'(PREG_ZERO);

  data_t                          mem [DEPTH];
  logic [DEPTH-1:0]               valid_nxt;
  logic                           conflict_nxt;
  logic [READ_PORT-1:0][DWIDTH-1:0] sel_data;
  logic [READ_PORT-1:0]           sel_ready;

  // Array update: ports applied in index order so the highest port wins a same-address tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int w = 0; w < WRITE_PORT; w++) begin
        if (write_valid[w] && (write_address[w] != ZERO_ADDR)) begin
          mem[write_address[w]] <= write_data[w];
        end
      end
    end
  end

  // Scoreboard next state: writes set ready, invalidates applied afterwards so they win; entry 0 pinned.
  always_comb begin
    valid_nxt = register_valid;
    for (int w = 0; w < WRITE_PORT; w++) begin
      if (write_valid[w] && (write_address[w] != ZERO_ADDR)) begin
        valid_nxt[write_address[w]] = 1'b1;
      end
    end
    for (int i = 0; i < INV_PORT; i++) begin
      if (invalidate_register[i] != ZERO_ADDR) begin
        valid_nxt[invalidate_register[i]] = 1'b0;
      end
    end
    valid_nxt[PREG_ZERO] = 1'b1;
  end

  // Flag any pair of active write ports aimed at the same nonzero register.
  always_comb begin
    conflict_nxt = 1'b0;
    for (int a = 0; a < WRITE_PORT; a++) begin
      for (int b = a + 1; b < WRITE_PORT; b++) begin
        if (write_valid[a] && write_valid[b] &&
            (write_address[a] == write_address[b]) &&
            (write_address[a] != ZERO_ADDR)) begin
          conflict_nxt = 1'b1;
        end
      end
    end
  end

  // Scoreboard and conflict registers; reset discards whatever arrived in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      register_valid <= '1;
      write_conflict <= 1'b0;
    end else begin
      register_valid <= valid_nxt;
      write_conflict <= conflict_nxt;
    end
  end

  genvar r;
  generate
    for (r = 0; r < READ_PORT; r++) begin : g_rd
      regbank_bypass_mux #(
        .DWIDTH     (DWIDTH),
        .AWIDTH     (AWIDTH),
        .WRITE_PORT (WRITE_PORT),
        .BYPASS     (BYPASS)
      ) u_mux (
        .read_addr     (read_addr[r]),
        .write_valid   (write_valid),
        .write_address (write_address),
        .write_data    (write_data),
        .array_data    (mem[read_addr[r]]),
        .array_valid   (register_valid[read_addr[r]]),
        .sel_data      (sel_data[r]),
        .sel_ready     (sel_ready[r])
      );
    end

    if (READ_LATENCY == 0) begin : g_rd_comb
      assign read_data  = sel_data;
      assign read_ready = sel_ready;
    end else begin : g_rd_reg
      // Registered read: capture the combinational operand at the edge.
      always_ff @(posedge clk) begin
        if (reset) begin
          read_data  <= '0;
          read_ready <= '0;
        end else begin
          read_data  <= sel_data;
          read_ready <= sel_ready;
        end
      end
    end
  endgenerate

endmodule
